lif_scheduler: RTL and testbench

- Time-multiplexes one shared LIF update datapath across NUM_NEURONS virtual neurons.
- Holds each neuron's 8-bit membrane state in an internal register array.
- On each timestep request, updates the neurons one per cycle in index order.
- Returns a registered spike vector and a done pulse.
- Owns the threshold/beta configuration that the datapath consumes.

---
 rtl/lif_pkg.sv | 16 +
 rtl/lif_update_unit.sv | 28 ++
 rtl/lif_scheduler.sv | 123 ++++++++++++
 tb/tb_lif_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared widths, reset defaults and FSM state encoding for the LIF scheduler.
package lif_pkg;

  localparam int STATE_W = 8;
  localparam int BETA_W  = 3;

  localparam logic [STATE_W-1:0] LIF_THRESH_RST = 8'd230;
  localparam logic [BETA_W-1:0]  LIF_BETA_RST   = 3'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } lif_state_e;

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leaky integrate-and-fire update for one neuron.
module lif_update_unit
  import lif_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] current,
  input  logic [STATE_W-1:0] threshold,
  input  logic [BETA_W-1:0]  beta,
  output logic [STATE_W-1:0] next_state,
  output logic               spike
);

  logic [STATE_W:0] sum;

  always_comb begin
    spike = (state >= threshold);
    // One extra bit so overflow clamps to full scale instead of wrapping.
    sum = {1'b0, current} + {1'b0, state >> beta};
    if (spike) begin
      next_state = '0;
    end else if (sum[STATE_W]) begin
      next_state = '1;
    end else begin
      next_state = sum[STATE_W-1:0];
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexes one LIF update unit across NUM_NEURONS virtual neurons,
// one neuron per cycle per timestep, and owns the threshold/beta config.
//
// state  | meaning
// IDLE   | waiting; accepts config, clear and timestep start
// UPDATE | updating neuron idx, one per cycle
// DONE   | done pulse; new spikes visible
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int                 NUM_NEURONS = 4,
  parameter int                 IDX_W       = $clog2(NUM_NEURONS),
  parameter logic [STATE_W-1:0] THRESH_RST  = LIF_THRESH_RST,
  parameter logic [BETA_W-1:0]  BETA_RST    = LIF_BETA_RST
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           step_start,
  input  logic [STATE_W*NUM_NEURONS-1:0] currents,
  input  logic                           cfg_we,
  input  logic [STATE_W-1:0]             cfg_threshold,
  input  logic [BETA_W-1:0]              cfg_beta,
  input  logic                           clear_states,
  input  logic [IDX_W-1:0]               rd_addr,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_NEURONS-1:0]         spikes,
  output logic [STATE_W-1:0]             rd_state
);

  lif_state_e           fsm_q;
  logic [IDX_W-1:0]     idx_q;
  logic [STATE_W-1:0]   mem_q [NUM_NEURONS];
  logic [STATE_W-1:0]   cur_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] acc_q;
  logic [NUM_NEURONS-1:0] acc_upd;
  logic [STATE_W-1:0]   threshold_q;
  logic [BETA_W-1:0]    beta_q;
  logic [STATE_W-1:0]   upd_next;
  logic                 upd_spike;
  logic                 last_idx;

  lif_update_unit u_update (
    .state      (mem_q[idx_q]),
    .current    (cur_q[idx_q]),
    .threshold  (threshold_q),
    .beta       (beta_q),
    .next_state (upd_next),
    .spike      (upd_spike)
  );

  assign busy     = (fsm_q != IDLE);
  assign last_idx = (idx_q == IDX_W'(NUM_NEURONS - 1));

  always_comb begin
    acc_upd        = acc_q;
    acc_upd[idx_q] = upd_spike;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      threshold_q <= THRESH_RST;
      beta_q      <= BETA_RST;
      done        <= 1'b0;
      spikes      <= '0;
      rd_state    <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem_q[i] <= '0;
        cur_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (fsm_q)
        IDLE: begin
          // Config lands on the same edge as the start, so that timestep sees it.
          if (cfg_we) begin
            threshold_q <= cfg_threshold;
            beta_q      <= cfg_beta;
          end
          if (clear_states) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
              mem_q[i] <= '0;
            end
          end else if (step_start) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
              cur_q[i] <= currents[STATE_W*i +: STATE_W];
            end
            acc_q <= '0;
            idx_q <= '0;
            fsm_q <= UPDATE;
          end
        end
        UPDATE: begin
          mem_q[idx_q] <= upd_next;
          acc_q        <= acc_upd;
          if (last_idx) begin
            // Spikes are published on entry to DONE so they line up with the pulse.
            spikes <= acc_upd;
            done   <= 1'b1;
            fsm_q  <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          idx_q <= '0;
          fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase

      if (int'(rd_addr) < NUM_NEURONS) begin
        rd_state <= mem_q[rd_addr];
      end else begin
        rd_state <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lif_scheduler.sv
// Randomized self-checking bench for lif_scheduler against an array-based model.
module tb_lif_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           step_start;
  logic [8*N-1:0] currents;
  logic           cfg_we;
  logic [7:0]     cfg_threshold;
  logic [2:0]     cfg_beta;
  logic           clear_states;
  logic [1:0]     rd_addr;
  logic           busy;
  logic           done;
  logic [N-1:0]   spikes;
  logic [7:0]     rd_state;

  int m_state [N];
  int m_thr;
  int m_beta;
  logic [N-1:0] m_spikes;

  int n_checks = 0;
  int n_pass   = 0;

  lif_scheduler #(.NUM_NEURONS(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .step_start    (step_start),
    .currents      (currents),
    .cfg_we        (cfg_we),
    .cfg_threshold (cfg_threshold),
    .cfg_beta      (cfg_beta),
    .clear_states  (clear_states),
    .rd_addr       (rd_addr),
    .busy          (busy),
    .done          (done),
    .spikes        (spikes),
    .rd_state      (rd_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_state[i] = 0;
    m_thr    = 230;
    m_beta   = 1;
    m_spikes = '0;
  endtask

  task automatic model_step(input logic [8*N-1:0] cur);
    int s, c, sum;
    for (int i = 0; i < N; i++) begin
      s = m_state[i];
      c = int'(cur[8*i +: 8]);
      sum = c + (s >> m_beta);
      m_spikes[i] = (s >= m_thr);
      if (s >= m_thr) m_state[i] = 0;
      else            m_state[i] = (sum > 255) ? 255 : sum;
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rd_addr = 2'(i);
      @(negedge clk);
      check($sformatf("%s:rd%0d", tag, i), int'(rd_state), m_state[i]);
    end
  endtask

  task automatic run_step(input logic [8*N-1:0] cur, input bit with_cfg,
                          input logic [7:0] th, input logic [2:0] be,
                          input bit disturb, input string tag);
    int cyc;
    int extra;
    @(negedge clk);
    step_start = 1'b1;
    currents   = cur;
    if (with_cfg) begin
      cfg_we        = 1'b1;
      cfg_threshold = th;
      cfg_beta      = be;
      m_thr         = int'(th);
      m_beta        = int'(be);
    end
    @(negedge clk);
    step_start = 1'b0;
    cfg_we     = 1'b0;
    currents   = $urandom;
    model_step(cur);
    check({tag, ":busy"}, int'(busy), 1);
    cyc = 1;
    if (disturb) begin
      step_start    = 1'b1;
      cfg_we        = 1'b1;
      cfg_threshold = 8'd5;
      cfg_beta      = 3'd7;
      clear_states  = 1'b1;
      @(negedge clk);
      step_start   = 1'b0;
      cfg_we       = 1'b0;
      clear_states = 1'b0;
      cyc++;
    end
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ":latency"}, cyc, N + 1);
    check({tag, ":spikes"}, int'(spikes), int'(m_spikes));
    extra = 0;
    @(negedge clk);
    check({tag, ":idle"}, int'(busy), 0);
    if (done) extra++;
    repeat (N + 2) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, ":extra_done"}, extra, 0);
    check({tag, ":spikes_hold"}, int'(spikes), int'(m_spikes));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_states = 1'b1;
    @(negedge clk);
    clear_states = 1'b0;
    for (int i = 0; i < N; i++) m_state[i] = 0;
  endtask

  initial begin
    logic [8*N-1:0] cur;
    int extra;

    rst = 1'b1; step_start = 1'b0; currents = '0; cfg_we = 1'b0;
    cfg_threshold = '0; cfg_beta = '0; clear_states = 1'b0; rd_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst:busy", int'(busy), 0);
    check("rst:done", int'(done), 0);
    check("rst:spikes", int'(spikes), 0);
    check("rst:rd_state", int'(rd_state), 0);
    rst = 1'b0;
    read_all("rst");

    // Integration without spiking: 100, 150, 175, 187.
    for (int k = 0; k < 4; k++) begin
      run_step({4{8'd100}}, 1'b0, 8'd0, 3'd0, 1'b0, $sformatf("int%0d", k));
      read_all($sformatf("int%0d", k));
    end

    // Saturation then spike on neuron 2.
    pulse_clear();
    for (int k = 0; k < 3; k++) begin
      run_step({8'd0, 8'd200, 8'd0, 8'd0}, 1'b0, 8'd0, 3'd0, 1'b0, $sformatf("sat%0d", k));
      read_all($sformatf("sat%0d", k));
    end

    // Low threshold, no leak.
    pulse_clear();
    @(negedge clk);
    cfg_we = 1'b1; cfg_threshold = 8'd50; cfg_beta = 3'd0;
    @(negedge clk);
    cfg_we = 1'b0; m_thr = 50; m_beta = 0;
    for (int k = 0; k < 3; k++) begin
      run_step({4{8'd40}}, 1'b0, 8'd0, 3'd0, 1'b0, $sformatf("low%0d", k));
      read_all($sformatf("low%0d", k));
    end

    // Start/config/clear while busy are ignored.
    run_step({4{8'd30}}, 1'b0, 8'd0, 3'd0, 1'b1, "dist0");
    read_all("dist0");
    run_step({4{8'd30}}, 1'b0, 8'd0, 3'd0, 1'b0, "dist1");
    read_all("dist1");

    // Asynchronous reset while updating neuron 2.
    @(negedge clk);
    step_start = 1'b1; currents = {4{8'd250}};
    @(negedge clk);
    step_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst:busy", int'(busy), 0);
    check("midrst:spikes", int'(spikes), 0);
    check("midrst:done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    read_all("midrst");
    run_step({4{8'd200}}, 1'b0, 8'd0, 3'd0, 1'b0, "post0");
    run_step({4{8'd20}}, 1'b0, 8'd0, 3'd0, 1'b0, "post1");
    read_all("post1");

    // Clear and start together: clear wins, start dropped.
    @(negedge clk);
    clear_states = 1'b1; step_start = 1'b1; currents = {4{8'd77}};
    @(negedge clk);
    clear_states = 1'b0; step_start = 1'b0;
    check("clrstart:busy", int'(busy), 0);
    extra = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("clrstart:no_run", extra, 0);
    for (int i = 0; i < N; i++) m_state[i] = 0;
    read_all("clrstart");

    // Randomized timesteps, sometimes with same-cycle config.
    for (int k = 0; k < 12; k++) begin
      cur = $urandom;
      if ($urandom_range(0, 5) == 0) pulse_clear();
      run_step(cur, ($urandom_range(0, 2) == 0), 8'($urandom_range(60, 255)),
               3'($urandom_range(0, 3)), 1'b0, $sformatf("rnd%0d", k));
      read_all($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
